// File: rtl/risc_sequencer.sv
// -----------------------------------------------------------------------------
// risc_sequencer
//
// Phase sequencer for the basic RISC core. A registered state machine walks
// FETCH -> DECODE -> EXECUTE (-> MWAIT ...) -> UPDATE and decodes the datapath
// strobes combinationally from the current state, the IR fields, the flags
// latched at the end of DECODE and the RAM ready handshake. A HALT opcode or a
// RAM access that never completes parks the machine in HALT until reset.
//
// Parameters
//   AW        address field width
//   REG_BASE  address of the first memory-mapped register target
//   NREG      number of register targets; the last one is the I/O port
//   MAX_WAIT  MWAIT cycles tolerated before the timeout halt (1..255)
//
// Ports
//   CLK, RST          clock (rising edge), synchronous active-high reset
//   OPCODE, ADDR, IF  instruction register fields
//   ZF, OF, SF, CF    ALU flags, sampled when DECODE is left
//   MEM_RDY           RAM access completes this cycle
//   PH                phase code (0 FETCH, 1 DECODE/HALT, 2 EXECUTE/MWAIT, 3 UPDATE)
//   HALTED, ERR       in HALT / halted by access timeout
//   IR_EN, PC_EN, PC_LOAD, REG_EN, RDR_EN, ALU_EN, ALU_OE,
//   RAM_OE, RAM_WE, PORT_RD, RAM_CS (active-low)   datapath strobes
// -----------------------------------------------------------------------------
module risc_sequencer #(
  parameter int AW       = 7,
  parameter int REG_BASE = 64,
  parameter int NREG     = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      OPCODE,
  input  logic [AW-1:0]   ADDR,
  input  logic            IF,
  input  logic            ZF,
  input  logic            OF,
  input  logic            SF,
  input  logic            CF,
  input  logic            MEM_RDY,
  output logic [1:0]      PH,
  output logic            HALTED,
  output logic            ERR,
  output logic            IR_EN,
  output logic            PC_EN,
  output logic            PC_LOAD,
  output logic [NREG-1:0] REG_EN,
  output logic            RDR_EN,
  output logic            ALU_EN,
  output logic            ALU_OE,
  output logic            RAM_OE,
  output logic            RAM_WE,
  output logic            PORT_RD,
  output logic            RAM_CS
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MWAIT   = 3'd3,
    S_UPDATE  = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_HALT  = 4'd15;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_wait_cnt;
  logic [7:0]      w_wait_cnt_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic            r_zf;
  logic            r_of;
  logic            r_sf;
  logic            r_cf;

  logic [31:0]     w_addr_ext;
  logic [NREG-1:0] w_reg_sel;
  logic            w_is_port;
  logic            w_is_mem;
  logic [8:0]      w_wait_inc;
  logic            w_timeout;
  logic            w_taken;

  assign w_addr_ext = 32'(ADDR);

  // LOAD IF=0 and every STORE go through the RAM handshake.
  assign w_is_mem = ((OPCODE == OP_LOAD) && !IF) || (OPCODE == OP_STORE);

  // The last register target is the I/O port.
  assign w_is_port = (w_addr_ext == 32'(REG_BASE + NREG - 1));

  // Widened so the compare cannot wrap at MAX_WAIT = 255. The check uses the
  // post-increment value so that exactly MAX_WAIT stalled MWAIT cycles are
  // tolerated after the stalled EXECUTE cycle.
  assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;
  assign w_timeout  = !MEM_RDY && (w_wait_inc == 9'(MAX_WAIT));

  // One-hot register target decode; out-of-range addresses select nothing.
  always_comb begin
    w_reg_sel = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      w_reg_sel[i] = (w_addr_ext == 32'(REG_BASE + i));
    end
  end

  // Branch decision from the flags captured at the end of DECODE.
  always_comb begin
    w_taken = 1'b0;
    case (OPCODE)
      4'd8:    w_taken = 1'b1;
      4'd9:    w_taken = r_zf;
      4'd10:   w_taken = r_sf;
      4'd11:   w_taken = r_of;
      4'd12:   w_taken = r_cf;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state, wait counter and error flag.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_err_nxt      = r_err;
    case (r_state)
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (OPCODE == OP_HALT) begin
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (w_is_mem && !MEM_RDY) begin
          w_state_nxt = S_MWAIT;
        end else begin
          w_state_nxt = S_UPDATE;
        end
      end
      S_MWAIT: begin
        if (MEM_RDY || !w_is_mem) begin
          w_state_nxt = S_UPDATE;
        end else if (w_timeout) begin
          w_state_nxt = S_HALT;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt    = S_MWAIT;
          w_wait_cnt_nxt = w_wait_inc[7:0];
        end
      end
      S_UPDATE: begin
        w_state_nxt    = S_FETCH;
        w_wait_cnt_nxt = 8'd0;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt    = S_FETCH;
        w_wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  // State, wait counter, error and latched flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
      r_zf       <= 1'b0;
      r_of       <= 1'b0;
      r_sf       <= 1'b0;
      r_cf       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_err      <= w_err_nxt;
      if (r_state == S_DECODE) begin
        r_zf <= ZF;
        r_of <= OF;
        r_sf <= SF;
        r_cf <= CF;
      end else begin
        r_zf <= r_zf;
        r_of <= r_of;
        r_sf <= r_sf;
        r_cf <= r_cf;
      end
    end
  end

  // Datapath strobes. RST forces the idle set in the same cycle so that an
  // aborted access never emits a partial REG_EN or RAM_WE pulse.
  always_comb begin
    PH      = 2'd0;
    HALTED  = 1'b0;
    ERR     = 1'b0;
    IR_EN   = 1'b0;
    PC_EN   = 1'b0;
    PC_LOAD = 1'b0;
    REG_EN  = {NREG{1'b0}};
    RDR_EN  = 1'b0;
    ALU_EN  = 1'b0;
    ALU_OE  = 1'b0;
    RAM_OE  = 1'b0;
    RAM_WE  = 1'b0;
    PORT_RD = 1'b1;
    RAM_CS  = 1'b1;
    if (RST) begin
      PH = 2'd0;
    end else begin
      ERR = r_err;
      case (r_state)
        S_FETCH: begin
          PH    = 2'd0;
          IR_EN = 1'b1;
        end
        S_DECODE: begin
          PH = 2'd1;
        end
        S_EXECUTE, S_MWAIT: begin
          PH = 2'd2;
          case (OPCODE)
            OP_LOAD: begin
              if (IF) begin
                // Immediate: value comes from the port side, completes now.
                REG_EN = w_reg_sel;
              end else begin
                RAM_CS  = 1'b0;
                RAM_OE  = 1'b1;
                RDR_EN  = 1'b1;
                PORT_RD = 1'b0;
                if (MEM_RDY) begin
                  REG_EN = w_reg_sel;
                end else begin
                  REG_EN = {NREG{1'b0}};
                end
              end
            end
            OP_STORE: begin
              RAM_CS = 1'b0;
              RAM_WE = MEM_RDY;
              if (w_is_port) begin
                PORT_RD = 1'b1;
                ALU_OE  = 1'b0;
              end else begin
                PORT_RD = 1'b0;
                ALU_OE  = 1'b1;
              end
            end
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
              ALU_EN = 1'b1;
            end
            default: begin
              ALU_EN = 1'b0;
            end
          endcase
        end
        S_UPDATE: begin
          PH      = 2'd3;
          PC_EN   = 1'b1;
          PC_LOAD = w_taken;
        end
        S_HALT: begin
          PH     = 2'd1;
          HALTED = 1'b1;
        end
        default: begin
          PH = 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Parametrised, clocked instruction sequencer for the basic RISC core. It owns the FETCH/DECODE/EXECUTE/UPDATE phase state machine and drives the datapath strobes from that state. The memory-mapped register targets are a parameter (`NREG` one-hot enables), and RAM accesses use a `MEM_RDY` wait handshake with a timeout. A HALT opcode stops execution. It sits between the instruction register (`OPCODE`/`ADDR`/`IF` fields), the ALU flag outputs, and the register/RAM/port/PC enables.

## Interface
- `AW`, default 7: address field width.
- `REG_BASE`, default 64: address of the first memory-mapped register target (A=64, B=65, PDR=66, PORT=67 at defaults).
- `NREG`, default 4: number of register targets at `REG_BASE .. REG_BASE+NREG-1`. The last target is the I/O port.
- `MAX_WAIT`, default 15: number of `MWAIT` cycles tolerated before the error halt. Range 1..255.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: one clock; reset is synchronous and active-high.
- `OPCODE` in 4: from the IR, stable DECODE..UPDATE.
- `ADDR` in AW: from the IR.
- `IF` in 1: immediate flag.
- `ZF`, `OF`, `SF`, `CF` in 1 each: ALU flags.
- `MEM_RDY` in 1: RAM access completes this cycle.
- `PH` out 2: phase code, FETCH=0, DECODE=1, EXECUTE=2, UPDATE=3.
- `HALTED` out 1: in HALT.
- `ERR` out 1: halted by timeout.
- `IR_EN`, `PC_EN`, `PC_LOAD` out 1 each.
- `REG_EN` out NREG: one-hot register load.
- `RDR_EN`, `ALU_EN`, `ALU_OE`, `RAM_OE`, `RAM_WE`, `PORT_RD` out 1 each.
- `RAM_CS` out 1: active-low.

## Operation
- States are FETCH, DECODE, EXECUTE, MWAIT, UPDATE and HALT, in a registered state machine.
- Outputs decode combinationally from the state, `OPCODE`/`ADDR`/`IF`, the latched flags and `MEM_RDY` only.
- Idle output set, applied to every output not listed for a state: `IR_EN`, `PC_EN`, `PC_LOAD`, `REG_EN`, `RDR_EN`, `ALU_EN`, `ALU_OE`, `RAM_OE`, `RAM_WE` = 0; `RAM_CS` = 1; `PORT_RD` = 1.
- Reset: while `RST`=1, all outputs are idle with `PH`=0, `HALTED`=0 and `ERR`=0. On the edge, the state becomes FETCH and the wait counter and latched flags clear.
- FETCH: `IR_EN`=1. Next state is DECODE.
- DECODE:
  - Flags `ZF`/`OF`/`SF`/`CF` are latched on the exiting edge.
  - `OPCODE`=15 goes to HALT (PC not advanced). All other opcodes go to EXECUTE.
- EXECUTE and MWAIT drive the opcode strobes, with `PH`=2 in both states:
  - LOAD (0), `IF`=1: `PORT_RD`=1, no RAM access.
  - LOAD (0), `IF`=0: `RAM_CS`=0, `RAM_OE`=1, `RDR_EN`=1, `PORT_RD`=0.
  - LOAD target: `REG_EN[ADDR-REG_BASE]`=1 only in the completing cycle, and only if `ADDR` is in range. Out-of-range targets load nothing.
  - STORE (1): `RAM_CS`=0. If `ADDR`=`REG_BASE+NREG-1`, the source is the port (`PORT_RD`=1, `ALU_OE`=0). Otherwise `ALU_OE`=1 and `PORT_RD`=0. `RAM_WE`=1 only in the completing cycle.
  - Opcodes 2–7: `ALU_EN`=1.
  - Opcodes 8–14: no strobes.
- Memory access is a LOAD with `IF`=0 or any STORE:
  - It completes in the first EXECUTE/MWAIT cycle with `MEM_RDY`=1; the next state is then UPDATE.
  - EXECUTE with `MEM_RDY`=0 goes to MWAIT.
  - Each MWAIT cycle with `MEM_RDY`=0 increments the wait counter.
  - If the counter equals `MAX_WAIT` and `MEM_RDY`=0, the next state is HALT with `ERR` set.
- Non-memory opcodes complete in EXECUTE.
- UPDATE: `PC_EN`=1, and `PC_LOAD`=1 when the branch is taken:
  - 8: always.
  - 9: latched ZF.
  - 10: latched SF.
  - 11: latched OF.
  - 12: latched CF.
  - The wait counter clears. Next state is FETCH.
- HALT: idle outputs, `HALTED`=1, `PH`=1. Exit is by `RST` only. `ERR` holds until reset.

## Timing
- Non-memory or immediate instruction: 4 cycles, FETCH→UPDATE.
- Memory instruction that sees N cycles of `MEM_RDY`=0: 4+N cycles.
- Timeout: EXECUTE plus `MAX_WAIT` MWAIT cycles, all with `MEM_RDY`=0, then HALT.
- `MEM_RDY` is ignored outside EXECUTE/MWAIT and for non-memory opcodes.
- `MEM_RDY` that rises in the same cycle the counter reaches `MAX_WAIT` completes the access normally; no error.
- `RST` mid-instruction (any state, including MWAIT/HALT) aborts the instruction: outputs go idle in the same cycle and FETCH follows. No partial `REG_EN` or `RAM_WE` pulse.
- Flags changing during EXECUTE/UPDATE do not affect the branch decision.

## Test plan
- Reset, then ADD (opcode 2) → `PH` sequence 0,1,2,3,0; `IR_EN` high in cycle 0 only; `ALU_EN` high in cycle 2; `PC_EN`=1, `PC_LOAD`=0 in cycle 3.
- LOAD `IF`=0, `ADDR`=65, `MEM_RDY` low for 3 cycles → 7-cycle instruction; `RAM_CS`=0 throughout EXECUTE/MWAIT; `REG_EN`=4'b0010 for exactly one cycle, aligned with `MEM_RDY`=1.
- STORE `ADDR`=67 vs `ADDR`=10, with `MEM_RDY`=1 → port case gives `PORT_RD`=1, `ALU_OE`=0; RAM case gives `PORT_RD`=0, `ALU_OE`=1; `RAM_WE` is a single pulse in EXECUTE in both cases.
- BZ (9) with `ZF`=1 at DECODE, then `ZF`=0 during EXECUTE → `PC_LOAD`=1 in UPDATE. Repeat with `ZF`=0 at DECODE → `PC_LOAD`=0.
- LOAD `IF`=0 with `MEM_RDY` stuck low, `MAX_WAIT`=15 → HALT after 16 access cycles; `HALTED`=`ERR`=1, idle outputs; stays halted until `RST`.
- HALT opcode (15) → HALT directly after DECODE with `PC_EN` never asserted. `RST` asserted during MWAIT → idle outputs that cycle, FETCH next, no `REG_EN` pulse.
